// File: rtl/tl_pkg.sv
// Shared transaction-layer types: completion command, 128-bit link stream beat,
// credit snapshot, 3DW completion header and the completion status encoder.
package tl_pkg;

   localparam logic [7:0] TLP_FMTTYPE_CPL  = 8'h0A;
   localparam logic [7:0] TLP_FMTTYPE_CPLD = 8'h4A;

   typedef enum logic [2:0] {
      CPL_SUCCESS = 3'b000,
      CPL_UR      = 3'b001,
      CPL_CRS     = 3'b010,
      CPL_CA      = 3'b100
   } tl_cpl_status_e;

   typedef struct packed {
      logic [255:0]   data;
      logic [15:0]    requester_id;
      logic [7:0]     tag;
      logic [6:0]     lower_addr;
      logic [11:0]    byte_count;
      tl_cpl_status_e status;
      logic           has_data;
   } cpl_gen_cmd_t;

   typedef struct packed {
      logic [127:0] data;
      logic [3:0]   be;
      logic         sop;
      logic         eop;
      logic         is_dllp;
   } tl_stream_t;

   typedef struct packed {
      logic [7:0]  ph;
      logic [11:0] pd;
      logic [7:0]  nph;
      logic [11:0] npd;
      logic [7:0]  cplh;
      logic [11:0] cpld;
   } tl_credit_t;

   // Field order puts DW0 in bits [31:0] so the header drops straight into the stream.
   typedef struct packed {
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic        rsvd2;
      logic [6:0]  lower_addr;
      logic [15:0] completer_id;
      logic [2:0]  status;
      logic        bcm;
      logic [11:0] byte_count;
      logic [7:0]  fmt_type;
      logic        rsvd0a;
      logic [2:0]  tc;
      logic [9:0]  rsvd0b;
      logic [9:0]  length;
   } tl_cpl_hdr_t;

   function automatic logic [2:0] cpl_status_enc(input tl_cpl_status_e status);
      logic [2:0] code;
      case (status)
         CPL_SUCCESS: code = 3'b000;
         CPL_UR:      code = 3'b001;
         CPL_CA:      code = 3'b100;
         default:     code = 3'b001;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/tl_cpl_hdr_build.sv
// Combinational 3DW Cpl/CplD header builder: command fields, own BDF and the
// already-clamped payload length in, packed header out.
module tl_cpl_hdr_build
   import tl_pkg::*;
#(
   parameter logic [2:0] TC = 3'd0
) (
   input  cpl_gen_cmd_t cmd,
   input  logic [15:0]  completer_id,
   input  logic [9:0]   len,
   output tl_cpl_hdr_t  hdr
);

   logic unused_data;
   assign unused_data = ^cmd.data;

   always_comb begin
      hdr              = '0;
      hdr.fmt_type     = cmd.has_data ? TLP_FMTTYPE_CPLD : TLP_FMTTYPE_CPL;
      hdr.tc           = TC;
      hdr.length       = len;
      hdr.completer_id = completer_id;
      hdr.status       = cpl_status_enc(cmd.status);
      hdr.bcm          = 1'b0;
      hdr.byte_count   = cmd.byte_count;
      hdr.requester_id = cmd.requester_id;
      hdr.tag          = cmd.tag;
      hdr.rsvd2        = 1'b0;
      hdr.lower_addr   = cmd.lower_addr;
   end

endmodule

// File: rtl/tl_cpl_tx_framer.sv
// Frames completion commands into 1..3 beat Cpl/CplD TLPs on the 128-bit link stream.
// Define TL_CPL_CREDIT_CHK_EN to gate launch on CPLH/CPLD credits and report consumption.
module tl_cpl_tx_framer
   import tl_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD_DW = 8,
   parameter int unsigned TC             = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  cpl_gen_cmd_t cmd_i,
   input  logic [15:0]  completer_id_i,
   input  tl_credit_t   credit_avail_i,
   output logic         tx_valid_o,
   input  logic         tx_ready_i,
   output tl_stream_t   tx_o,
   output logic         cplh_consume_o,
   output logic [1:0]   cpld_consume_o,
   output logic         err_len_o
);

   localparam logic [12:0] MAX_N = 13'(MAX_PAYLOAD_DW);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_CRED,
      ST_SEND
   } state_e;

   state_e       state;
   logic [1:0]   beat_idx;
   logic         cplh_pulse;
   logic [1:0]   cpld_pulse;

   logic [383:0] frame_q;
   logic [1:0]   last_beat_q;
   logic [3:0]   be_last_q;
   logic [1:0]   cpld_units_q;

   logic [12:0]  n_dw;
   logic         len_clamp;
   logic [9:0]   len;
   logic [3:0]   dw_total;
   logic [1:0]   last_beat_new;
   logic [3:0]   last_cnt;
   logic [3:0]   be_last_new;
   logic [1:0]   cpld_units_new;
   tl_cpl_hdr_t  hdr_new;
   logic         cred_ok_new;
   logic         cred_ok_held;
   logic         accept;

   assign accept = cmd_valid_i && cmd_ready_o;

   // Payload length in DW, rounded out from the first byte's DW offset.
   always_comb begin
      n_dw      = (13'(cmd_i.lower_addr[1:0]) + 13'(cmd_i.byte_count) + 13'd3) >> 2;
      len_clamp = cmd_i.has_data && ((cmd_i.byte_count == 12'd0) || (n_dw > MAX_N));
      if (!cmd_i.has_data)
         len = 10'd0;
      else if (len_clamp)
         len = MAX_N[9:0];
      else
         len = n_dw[9:0];
   end

   always_comb begin
      dw_total       = 4'd3 + len[3:0];
      last_beat_new  = 2'((dw_total - 4'd1) >> 2);
      last_cnt       = dw_total - {last_beat_new, 2'b00};
      cpld_units_new = 2'((len + 10'd3) >> 2);
      case (last_cnt)
         4'd1:    be_last_new = 4'b0001;
         4'd2:    be_last_new = 4'b0011;
         4'd3:    be_last_new = 4'b0111;
         default: be_last_new = 4'b1111;
      endcase
   end

   tl_cpl_hdr_build #(
      .TC (3'(TC))
   ) u_hdr_build (
      .cmd          (cmd_i),
      .completer_id (completer_id_i),
      .len          (len),
      .hdr          (hdr_new)
   );

`ifdef TL_CPL_CREDIT_CHK_EN
   logic unused_credit;
   assign unused_credit  = ^{credit_avail_i.ph, credit_avail_i.pd,
                             credit_avail_i.nph, credit_avail_i.npd};
   assign cred_ok_new    = (credit_avail_i.cplh != 8'd0) &&
                           (credit_avail_i.cpld >= 12'(cpld_units_new));
   assign cred_ok_held   = (credit_avail_i.cplh != 8'd0) &&
                           (credit_avail_i.cpld >= 12'(cpld_units_q));
   assign cplh_consume_o = cplh_pulse;
   assign cpld_consume_o = cpld_pulse;
`else
   // Completions are treated as having infinite credit.
   logic unused_credit;
   assign unused_credit  = ^{credit_avail_i, cplh_pulse, cpld_pulse};
   assign cred_ok_new    = 1'b1;
   assign cred_ok_held   = 1'b1;
   assign cplh_consume_o = 1'b0;
   assign cpld_consume_o = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cmd_ready_o <= 1'b1;
         tx_valid_o  <= 1'b0;
         beat_idx    <= 2'd0;
         cplh_pulse  <= 1'b0;
         cpld_pulse  <= 2'd0;
         err_len_o   <= 1'b0;
      end else begin
         cplh_pulse <= 1'b0;
         cpld_pulse <= 2'd0;
         err_len_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmd_ready_o <= 1'b0;
                  err_len_o   <= len_clamp;
                  beat_idx    <= 2'd0;
                  if (cred_ok_new) begin
                     state      <= ST_SEND;
                     tx_valid_o <= 1'b1;
                     cplh_pulse <= 1'b1;
                     cpld_pulse <= cpld_units_new;
                  end else begin
                     state <= ST_WAIT_CRED;
                  end
               end
            end
            ST_WAIT_CRED: begin
               if (cred_ok_held) begin
                  state      <= ST_SEND;
                  tx_valid_o <= 1'b1;
                  cplh_pulse <= 1'b1;
                  cpld_pulse <= cpld_units_q;
               end
            end
            ST_SEND: begin
               if (tx_ready_i) begin
                  if (beat_idx == last_beat_q) begin
                     state       <= ST_IDLE;
                     tx_valid_o  <= 1'b0;
                     cmd_ready_o <= 1'b1;
                  end else begin
                     beat_idx <= beat_idx + 2'd1;
                  end
               end
            end
            default: begin
               state       <= ST_IDLE;
               tx_valid_o  <= 1'b0;
               cmd_ready_o <= 1'b1;
            end
         endcase
      end
   end

   // Whole packet is captured at accept; beats are then just slices of it.
   always_ff @(posedge clk) begin
      if (accept) begin
         frame_q      <= {32'h0, cmd_i.data, hdr_new};
         last_beat_q  <= last_beat_new;
         be_last_q    <= be_last_new;
         cpld_units_q <= cpld_units_new;
      end
   end

   logic is_last;
   assign is_last = (beat_idx == last_beat_q);

   always_comb begin
      tx_o = '0;
      if (tx_valid_o) begin
         case (beat_idx)
            2'd0:    tx_o.data = frame_q[127:0];
            2'd1:    tx_o.data = frame_q[255:128];
            default: tx_o.data = frame_q[383:256];
         endcase
         tx_o.sop     = (beat_idx == 2'd0);
         tx_o.eop     = is_last;
         tx_o.be      = is_last ? be_last_q : 4'b1111;
         tx_o.is_dllp = 1'b0;
      end
   end

endmodule
